// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file widths, zero-register index and write-request type
package regfile_pkg;

    localparam int ADDRESS_WIDTH = 5;
    localparam int DATA_WIDTH    = 32;
    localparam int NUM_REGS      = 1 << ADDRESS_WIDTH;

    localparam logic [4:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]    data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with a rotating priority pointer
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : request vector, one bit per requester
//   advance    : arbitration enable; no grant and pointer frozen while low
//   gnt        : one-hot grant (combinational)
//   gnt_idx    : index of the granted requester (0 when nothing granted)
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic          found;
    int            idx;

    // Scan ptr, ptr+1, ... modulo N; the first requester seen wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        ptr_d   = ptr_q;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (advance && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IW'(idx);
                ptr_d    = IW'((idx + 1) % N);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - round-robin sharing of the register-file write port among write-back sources
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   stall                 : blocks all grants while high
//   req_valid/addr/data   : per-requester pending write
//   req_ready             : one-hot combinational grant
//   WE3, AD3, WD3         : registered register-file write port
//   grant_idx             : requester behind the current WE3 pulse
//   busy                  : any request pending or a write in flight
module wb_port_arbiter #(
    parameter int NUM_REQ       = 3,
    parameter int ADDRESS_WIDTH = regfile_pkg::ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = regfile_pkg::DATA_WIDTH,
    parameter int GW            = $clog2(NUM_REQ)
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    stall,
    input  logic [NUM_REQ-1:0]                      req_valid,
    input  logic [NUM_REQ-1:0][ADDRESS_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]      req_data,
    output logic [NUM_REQ-1:0]                      req_ready,
    output logic                                    WE3,
    output logic [ADDRESS_WIDTH-1:0]                AD3,
    output logic [DATA_WIDTH-1:0]                   WD3,
    output logic [GW-1:0]                           grant_idx,
    output logic                                    busy
);

    import regfile_pkg::*;

    logic [NUM_REQ-1:0]       gnt;
    logic [GW-1:0]            gnt_idx;
    logic                     granted;
    logic [ADDRESS_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]    sel_data;

    logic                     we3_d, we3_q;
    logic [ADDRESS_WIDTH-1:0] ad3_d, ad3_q;
    logic [DATA_WIDTH-1:0]    wd3_d, wd3_q;
    logic [GW-1:0]            gidx_d, gidx_q;

    // Gating advance with rst_n keeps req_ready low during reset even though
    // the arbiter itself is purely combinational on its grant path.
    rr_arbiter #(.N(NUM_REQ), .IW(GW)) u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .advance (!stall && rst_n),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign granted   = |gnt;
    assign sel_addr  = req_addr[gnt_idx];
    assign sel_data  = req_data[gnt_idx];

    // A write to x0 is consumed but never enables the register file;
    // address and data still load so the attempt remains visible.
    always_comb begin
        we3_d  = 1'b0;
        ad3_d  = ad3_q;
        wd3_d  = wd3_q;
        gidx_d = gidx_q;
        if (granted) begin
            we3_d  = (sel_addr != ADDRESS_WIDTH'(ZERO_REG));
            ad3_d  = sel_addr;
            wd3_d  = sel_data;
            gidx_d = gnt_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we3_q  <= 1'b0;
            ad3_q  <= '0;
            wd3_q  <= '0;
            gidx_q <= '0;
        end else begin
            we3_q  <= we3_d;
            ad3_q  <= ad3_d;
            wd3_q  <= wd3_d;
            gidx_q <= gidx_d;
        end
    end

    assign WE3       = we3_q;
    assign AD3       = ad3_q;
    assign WD3       = wd3_q;
    assign grant_idx = gidx_q;
    assign busy      = (|req_valid) || we3_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - randomized self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   stall = 1'b0;
    logic [N-1:0]           req_valid = '0;
    logic [N-1:0][AW-1:0]   req_addr = '0;
    logic [N-1:0][DW-1:0]   req_data = '0;
    logic [N-1:0]           req_ready;
    logic                   WE3;
    logic [AW-1:0]          AD3;
    logic [DW-1:0]          WD3;
    logic [1:0]             grant_idx;
    logic                   busy;

    wb_port_arbiter #(.NUM_REQ(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .WE3       (WE3),
        .AD3       (AD3),
        .WD3       (WD3),
        .grant_idx (grant_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state: rotating priority start, expected output port, register file.
    int              m_ptr = 0;
    logic            m_we = 1'b0;
    logic [AW-1:0]   m_ad = '0;
    logic [DW-1:0]   m_wd = '0;
    int              m_gi = 0;
    logic [DW-1:0]   m_rf [32];
    logic [DW-1:0]   d_rf [32];

    // Register file driven by the DUT's write port.
    always @(posedge clk) begin
        if (rst_n && WE3) d_rf[AD3] <= WD3;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called at posedge+1 with inputs already driven; ends at the next posedge+1.
    task automatic cycle();
        int g;
        logic [N-1:0] er;
        #2;
        g = -1;
        if (!stall) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("busy", 64'(busy), 64'((|req_valid) || m_we));
        @(posedge clk);
        #1;
        if (g >= 0) begin
            m_we  = (req_addr[g] != 0);
            m_ad  = req_addr[g];
            m_wd  = req_data[g];
            m_gi  = g;
            m_ptr = (g + 1) % N;
            if (m_we) m_rf[req_addr[g]] = req_data[g];
        end else begin
            m_we = 1'b0;
        end
        chk("WE3", 64'(WE3), 64'(m_we));
        chk("AD3", 64'(AD3), 64'(m_ad));
        chk("WD3", 64'(WD3), 64'(m_wd));
        chk("grant_idx", 64'(grant_idx), 64'(m_gi));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        chk("rst_WE3", 64'(WE3), 64'd0);
        chk("rst_AD3", 64'(AD3), 64'd0);
        chk("rst_WD3", 64'(WD3), 64'd0);
        chk("rst_gidx", 64'(grant_idx), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        m_ptr = 0; m_we = 1'b0; m_ad = '0; m_wd = '0; m_gi = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i] = v;
        req_addr[i]  = a;
        req_data[i]  = d;
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin
            m_rf[r] = '0;
            d_rf[r] = '0;
        end
        req_valid = 3'b111;
        do_reset();
        req_valid = '0;

        // Single request from requester 1.
        set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
        cycle();
        chk("single_WE3", 64'(WE3), 64'd1);
        req_valid = '0;
        cycle();

        // All requesters valid continuously from reset.
        do_reset();
        set_req(0, 1'b1, 5'd10, 32'h100);
        set_req(1, 1'b1, 5'd11, 32'h101);
        set_req(2, 1'b1, 5'd12, 32'h102);
        for (int c = 0; c < 6; c++) begin
            cycle();
            chk("rr_order", 64'(grant_idx), 64'(c % N));
        end
        req_valid = '0;
        cycle();

        // Write to x0 is consumed but not enabled.
        set_req(2, 1'b1, 5'd0, 32'h1234);
        cycle();
        chk("x0_WE3", 64'(WE3), 64'd0);
        chk("x0_WD3", 64'(WD3), 64'h1234);
        req_valid = '0;
        cycle();

        // Stall for three cycles, then release.
        do_reset();
        stall = 1'b1;
        set_req(0, 1'b1, 5'd1, 32'hA0);
        set_req(1, 1'b1, 5'd2, 32'hA1);
        repeat (3) cycle();
        stall = 1'b0;
        cycle();
        chk("stall_first", 64'(grant_idx), 64'd0);
        req_valid[0] = 1'b0;
        cycle();
        chk("stall_second", 64'(grant_idx), 64'd1);
        req_valid = '0;
        cycle();

        // Reset asserted while a write to r7 is registered, pointer at 2.
        set_req(1, 1'b1, 5'd7, 32'h77);
        cycle();
        chk("pre_rst_AD3", 64'(AD3), 64'd7);
        req_valid = 3'b111;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_WE3", 64'(WE3), 64'd0);
        chk("async_ready", 64'(req_ready), 64'd0);
        m_ptr = 0; m_we = 1'b0; m_ad = '0; m_wd = '0; m_gi = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle();
        chk("post_rst_grant", 64'(grant_idx), 64'd0);
        req_valid = '0;
        cycle();

        // Same destination from two requesters, ptr at 0 after reset.
        do_reset();
        set_req(0, 1'b1, 5'd3, 32'hA);
        set_req(1, 1'b1, 5'd3, 32'hB);
        cycle();
        req_valid[0] = 1'b0;
        cycle();
        chk("dup_WE3_2nd", 64'(WE3), 64'd1);
        req_valid = '0;
        cycle();
        cycle();
        chk("dup_rf3", 64'(d_rf[3]), 64'hB);

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            stall = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < N; i++) begin
                set_req(i, 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                        32'($urandom));
            end
            cycle();
        end
        stall = 1'b0;
        req_valid = '0;
        cycle();
        cycle();

        for (int r = 0; r < 32; r++) chk("rf_final", 64'(d_rf[r]), 64'(m_rf[r]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
